// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the MEM stage and the
// data-memory responder.
//   req_*   : valid/ready request channel (store/load, size, sign, addr, data)
//   resp_*  : valid/ready response channel (extended load data, error flag)
// Modports: master = requester (MEM stage), slave = responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_size, req_sign, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_size, req_sign, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised little-endian data memory with a fixed
// access latency, serving one load/store at a time.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (array contents are kept)
//   bus  : dmem_responder_if.slave (request and response channels)
// Parameters:
//   ADDR_WIDTH : log2 of the array depth in 32-bit words
//   LATENCY    : edges from request acceptance to commit/response (1..15)
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// do not write, return rdata=0 and raise resp_err. Without it, misaligned
// addresses are force-aligned and resp_err is always 0.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Counter is loaded with LATENCY-1 so commit lands exactly LATENCY edges
  // after the accept edge (a single WAIT cycle for LATENCY=1).
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t state, state_nxt;
  logic   accept, commit;

  logic [3:0]            cnt;
  logic                  wen_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic                  misalign;
  logic [3:0]            be;
  logic [31:0]           wlane;
  logic [31:0]           rd_word;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           load_data;

  // Address bits above the array are ignored (accesses wrap).
  logic addr_hi_unused;
  assign addr_hi_unused = ^bus.req_addr[31:ADDR_WIDTH+2];

  assign idx = addr_q[ADDR_WIDTH+1:2];
  assign off = addr_q[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((size_q == 2'b01) && off[0]) || (size_q[1] && (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    commit         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte-lane enables/data for stores and sized/extended read data for loads.
  always_comb begin
    be        = '0;
    wlane     = wdata_q;
    rd_word   = mem[idx];
    sel_byte  = '0;
    load_data = '0;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << off;
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    if (misalign) be = '0;

    case (off)
      2'b00:   sel_byte = rd_word[7:0];
      2'b01:   sel_byte = rd_word[15:8];
      2'b10:   sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = off[1] ? rd_word[31:16] : rd_word[15:0];

    case (size_q)
      2'b00:   load_data = sign_q ? {{24{sel_byte[7]}}, sel_byte} : {24'd0, sel_byte};
      2'b01:   load_data = sign_q ? {{16{sel_half[15]}}, sel_half} : {16'd0, sel_half};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      wen_q   <= 1'b0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= CNT_LOAD;
        wen_q   <= bus.req_wen;
        size_q  <= bus.req_size;
        sign_q  <= bus.req_sign;
        addr_q  <= bus.req_addr[ADDR_WIDTH+1:0];
        wdata_q <= bus.req_wdata;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rdata_q <= (wen_q || misalign) ? '0 : load_data;
        err_q   <= misalign;
      end
    end
  end

  // Array has no reset; rst gating keeps an edge coinciding with reset from
  // committing an aborted store.
  always_ff @(posedge clk) begin
    if (commit && wen_q && !rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized bench for dmem_responder with a
// behavioural byte-addressed reference memory.
module tb_dmem_responder;
  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [1<<AW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory expressed with arithmetic.
  task automatic model(input bit wen, input logic [1:0] size, input bit sign,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] exp_rd, output bit exp_err);
    int unsigned widx, off, o;
    logic [31:0] mask, v;
    widx = (addr / 4) % (1 << AW);
    off  = addr % 4;
    o    = off - (off % 2);
    exp_err = TRAP && ((size == 2'd1 && off % 2 == 1) || (size >= 2'd2 && off != 0));
    exp_rd  = 32'd0;
    if (exp_err) return;
    if (wen) begin
      case (size)
        2'd0: begin
          mask = 32'hFF << (8 * off);
          mdl[widx] = (mdl[widx] & ~mask) | ((wdata & 32'hFF) << (8 * off));
        end
        2'd1: begin
          mask = 32'hFFFF << (8 * o);
          mdl[widx] = (mdl[widx] & ~mask) | ((wdata & 32'hFFFF) << (8 * o));
        end
        default: mdl[widx] = wdata;
      endcase
    end else begin
      case (size)
        2'd0: begin
          v = (mdl[widx] >> (8 * off)) & 32'hFF;
          if (sign && v >= 32'd128) v = v - 32'd256;
        end
        2'd1: begin
          v = (mdl[widx] >> (8 * o)) & 32'hFFFF;
          if (sign && v >= 32'd32768) v = v - 32'd65536;
        end
        default: v = mdl[widx];
      endcase
      exp_rd = v;
    end
  endtask

  task automatic access(input bit wen, input logic [1:0] size, input bit sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input string tag, output logic [31:0] obs);
    logic [31:0] er;
    bit ee;
    int n;
    @(negedge clk);
    bus.req_wen   = wen;
    bus.req_size  = size;
    bus.req_sign  = sign;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Captured request must not follow later input changes.
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'($urandom);
    bus.req_size  = 2'($urandom);
    bus.req_sign  = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    model(wen, size, sign, addr, wdata, er, ee);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      bus.resp_ready = 1'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    bus.resp_ready = 1'b0;
    check({tag, "/latency"}, 32'(n), 32'(LAT));
    check({tag, "/rdata"}, bus.resp_rdata, er);
    check({tag, "/err"}, 32'(bus.resp_err), 32'(ee));
    obs = bus.resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "/hold_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, "/hold_rdata"}, bus.resp_rdata, er);
      check({tag, "/hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check({tag, "/consumed"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "/ready_again"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [1:0]  sz;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_sign   = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst/req_ready", 32'(bus.req_ready), 32'd1);
    check("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst/resp_rdata", bus.resp_rdata, 32'd0);
    check("rst/resp_err", 32'(bus.resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word store/load and sized accesses.
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, "st_w10", rd);
    check("st_w10/zero", rd, 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "ld_w10", rd);
    check("ld_w10/const", rd, 32'hDEADBEEF);
    access(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000005A, 0, "st_b12", rd);
    access(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 0, "ld_b12s", rd);
    check("ld_b12s/const", rd, 32'h0000005A);
    access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, "ld_h12s", rd);
    check("ld_h12s/const", rd, 32'hFFFFDE5A);
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, "ld_b13s", rd);
    check("ld_b13s/const", rd, 32'hFFFFFFDE);
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 5, "ld_b13u_hold", rd);
    check("ld_b13u/const", rd, 32'h000000DE);

    // Wrap-around.
    access(1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678, 0, "st_wrap", rd);
    access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, "ld_wrap", rd);
    check("ld_wrap/const", rd, 32'h12345678);

    // Reset during WAIT aborts a pending store.
    access(1'b1, 2'd2, 1'b0, 32'h20, 32'h11111111, 0, "st_pre20", rd);
    access(1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 0, "ld_h0", rd);
    @(negedge clk);
    bus.req_wen   = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_sign  = 1'b0;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hFFFFFFFF;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("abort/in_wait", 32'(bus.req_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("abort/req_ready", 32'(bus.req_ready), 32'd1);
    check("abort/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort/resp_rdata", bus.resp_rdata, 32'd0);
    check("abort/resp_err", 32'(bus.resp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, "ld_after_abort", rd);
    check("ld_after_abort/const", rd, 32'h11111111);

    // Misaligned word store.
    access(1'b1, 2'd2, 1'b0, 32'h22, 32'hCAFEF00D, 0, "st_mis22", rd);
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, "ld_mis20", rd);
    check("ld_mis20/const", rd, TRAP ? 32'h11111111 : 32'hCAFEF00D);

    // Randomized traffic over words 0..15 with random ignored upper bits.
    for (int i = 0; i < 16; i++)
      access(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, "fill", rd);
    for (int i = 0; i < 80; i++) begin
      a  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      sz = 2'($urandom);
      access(1'($urandom), sz, 1'($urandom), a, $urandom,
             $urandom_range(0, 2), "rand", rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
